// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the fifo read-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Reader FSM: IDLE waits for data, HOLD decides framing of the held word,
    // SEND presents it on the stream until accepted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } rdr_state_t;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_pkt_reader_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear, flags expiry at TIMEOUT-1.
// Latency: expired reflects the registered count (no combinational path from en).
// Backpressure: none; saturates at the expiry value until cleared.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_clr        restart counting from zero (wins over i_en)
//   i_en         advance the count by one this cycle
//   o_expired    count has reached TIMEOUT-1
module idle_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            TW    = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    assign o_expired = (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains an FWFT fifo and frames the words into valid/ready packets (last on
// PKT_LEN beats, or on the final word after TIMEOUT empty cycles).
// Latency: pop to m_valid_o = 2 clk; 1 beat per 2 clk sustained.
// Backpressure: m_ready_i low holds data/last stable and stops fifo reads.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fifo_data_i, fifo_empty_i  fifo head word (valid when not empty)
//   fifo_rd_o                  pops the fifo head word
//   m_data_o, m_valid_o, m_ready_i, m_last_o   packet stream
//   flush_o                    one-cycle pulse when a packet is closed by timeout
//   pkt_cnt_o                  completed packets, wraps at 2^16
module fifo_pkt_reader
    import fifo_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int PKT_LEN = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_o,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              flush_o,
    output logic [15:0]       pkt_cnt_o
);

    localparam int            BW        = cnt_w(PKT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    rdr_state_t        r_state;
    rdr_state_t        w_state_nxt;
    logic [DWIDTH-1:0] r_hold;
    logic              r_last;
    logic              r_flush;
    logic [BW-1:0]     r_beat_cnt;
    logic [15:0]       r_pkt_cnt;

    logic w_rd;
    logic w_last_wr;
    logic w_last_val;
    logic w_flush_nxt;
    logic w_tmr_en;
    logic w_hs;
    logic w_expired;
    logic w_beat_last;

    assign w_beat_last = (r_beat_cnt == LAST_BEAT);

    // Timer restarts on every pop and only advances while HOLD is waiting
    // for either a successor word or the timeout.
    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_rd),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_last_wr   = 1'b0;
        w_last_val  = 1'b0;
        w_flush_nxt = 1'b0;
        w_tmr_en    = 1'b0;
        w_hs        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    w_rd        = 1'b1;
                    w_state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (w_beat_last) begin
                    // Packet length reached: last regardless of fifo state.
                    w_last_wr   = 1'b1;
                    w_last_val  = 1'b1;
                    w_state_nxt = SEND;
                end else if (!fifo_empty_i) begin
                    // A successor exists, so this beat cannot be the tail.
                    // The successor stays in the fifo until the handshake.
                    w_last_wr   = 1'b1;
                    w_last_val  = 1'b0;
                    w_state_nxt = SEND;
                end else if (w_expired) begin
                    w_last_wr   = 1'b1;
                    w_last_val  = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            SEND: begin
                if (m_ready_i) begin
                    w_hs = 1'b1;
                    if (!fifo_empty_i) begin
                        w_rd        = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_last     <= 1'b0;
            r_flush    <= 1'b0;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
            if (w_rd) begin
                r_hold <= fifo_data_i;
            end
            if (w_last_wr) begin
                r_last <= w_last_val;
            end
            if (w_hs) begin
                r_beat_cnt <= r_last ? '0 : (r_beat_cnt + BW'(1));
                if (r_last) begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                end
            end
        end
    end

    // Read strobe is gated by reset so the fifo never loses a word to a
    // block that is about to forget it.
    assign fifo_rd_o = w_rd && rst_n;
    assign m_valid_o = (r_state == SEND);
    assign m_data_o  = r_hold;
    assign m_last_o  = (r_state == SEND) && r_last;
    assign flush_o   = r_flush;
    assign pkt_cnt_o = r_pkt_cnt;

    a_rd_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_rd_o |-> !fifo_empty_i);

    a_idle_beat0: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) |-> (r_beat_cnt == '0));

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader with a behavioural FWFT fifo and a
// packet-framing scoreboard derived from burst lengths.
// Latency/backpressure exercised via directed steps and random ready.
module tb_fifo_pkt_reader;

    localparam int DW = 8;
    localparam int PL = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_rst;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          flush_o;
    logic [15:0]   pkt_cnt_o;

    always #5 clk = ~clk;

    fifo_pkt_reader #(
        .DWIDTH  (DW),
        .PKT_LEN (PL),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o),
        .flush_o      (flush_o),
        .pkt_cnt_o    (pkt_cnt_o)
    );

    // Behavioural FWFT fifo: writes land at negedge, pops at posedge.
    logic [DW-1:0] mem [0:255];
    int            wp = 0;
    int            rp = 0;

    assign fifo_empty_i = (wp == rp);
    assign fifo_data_i  = mem[rp[7:0]];

    always @(posedge clk) begin
        if (fifo_rst)       rp <= wp;
        else if (fifo_rd_o) rp <= rp + 1;
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] wr_q[$];
    int            hs_cyc_q[$];

    int n_assert   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int flush_seen = 0;
    int exp_flush  = 0;
    int exp_pkt    = 0;
    int hs_cnt     = 0;
    int last_hs_cyc  = 0;
    int last_pop_cyc = 0;
    bit track      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later (before the next posedge).
    task automatic tick(input bit rdy);
        beat_t b;
        @(negedge clk);
        cyc++;
        m_ready_i = rdy;
        if (rst_n && !fifo_rst && wr_q.size() > 0) begin
            mem[wp[7:0]] = wr_q.pop_front();
            wp++;
        end
        #1;
        if (!rst_n) return;
        if (flush_o) flush_seen++;
        if (fifo_rd_o) last_pop_cyc = cyc;
        if (m_valid_o && m_ready_i) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", 32'(m_data_o), 32'(b.d));
                chk("beat_last", 32'(m_last_o), 32'(b.l));
            end
            hs_cnt++;
            last_hs_cyc = cyc;
            if (track) hs_cyc_q.push_back(cyc);
        end
    endtask

    // Model: a back-to-back burst is cut into PL-word packets; a trailing
    // partial packet is closed by timeout with one flush pulse.
    task automatic push_burst(input int n, input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom) : DW'(base + DW'(i));
            wr_q.push_back(d);
            exp_q.push_back('{d: d, l: ((i % PL) == PL - 1) || (i == n - 1)});
        end
        if ((n % PL) != 0) exp_flush++;
        exp_pkt += (n + PL - 1) / PL;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((exp_q.size() > 0 || wr_q.size() > 0 || m_valid_o) && n < 3000) begin
            tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            n++;
        end
        chk("drain_in_budget", 32'(n < 3000), 32'd1);
        tick(1'b1);
        tick(1'b1);
        chk("pkt_cnt", 32'(pkt_cnt_o), 32'(exp_pkt[15:0]));
        chk("flush_cnt", 32'(flush_seen), 32'(exp_flush));
    endtask

    initial begin
        int            n;
        int            target;
        logic [DW-1:0] held_d;
        logic          held_l;

        rst_n     = 1'b0;
        fifo_rst  = 1'b1;
        m_ready_i = 1'b0;
        repeat (3) tick(1'b0);

        // Reset state
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_last",  32'(m_last_o),  32'd0);
        chk("rst_flush", 32'(flush_o),   32'd0);
        chk("rst_data",  32'(m_data_o),  32'd0);
        chk("rst_pkt",   32'(pkt_cnt_o), 32'd0);
        chk("rst_rd",    32'(fifo_rd_o), 32'd0);
        rst_n    = 1'b1;
        fifo_rst = 1'b0;
        tick(1'b1);

        // Full packet of 16: last only on 0xAF, no flush
        push_burst(16, 8'hA0, 1'b0);
        drain(1'b0);

        // Partial packet of 5 closed by timeout; valid rises on the TO-th
        // edge after the popping edge, seen one sample later.
        push_burst(5, 8'hB0, 1'b0);
        drain(1'b0);
        chk("timeout_latency", 32'(last_hs_cyc - last_pop_cyc), 32'(TO + 1));

        // 20 words: full packet then a 4-word timeout packet
        push_burst(20, 8'h10, 1'b0);
        drain(1'b0);

        // Stall with ready low for 10 cycles while valid
        push_burst(3, 8'hC0, 1'b0);
        n = 0;
        while (!m_valid_o && n < 50) begin
            tick(1'b0);
            n++;
        end
        chk("stall_valid_seen", 32'(m_valid_o), 32'd1);
        held_d = m_data_o;
        held_l = m_last_o;
        repeat (10) begin
            tick(1'b0);
            chk("stall_valid", 32'(m_valid_o), 32'd1);
            chk("stall_data",  32'(m_data_o),  32'(held_d));
            chk("stall_last",  32'(m_last_o),  32'(held_l));
            chk("stall_rd",    32'(fifo_rd_o), 32'd0);
        end
        drain(1'b0);

        // Reset after 7 beats of a 16-beat packet
        push_burst(16, 8'hD0, 1'b0);
        target = hs_cnt + 7;
        n = 0;
        while (hs_cnt < target && n < 100) begin
            tick(1'b1);
            n++;
        end
        chk("pre_reset_beats", 32'(hs_cnt), 32'(target));
        rst_n    = 1'b0;
        fifo_rst = 1'b1;
        wr_q.delete();
        exp_q.delete();
        tick(1'b1);
        tick(1'b1);
        chk("mid_rst_valid", 32'(m_valid_o), 32'd0);
        chk("mid_rst_last",  32'(m_last_o),  32'd0);
        chk("mid_rst_flush", 32'(flush_o),   32'd0);
        chk("mid_rst_data",  32'(m_data_o),  32'd0);
        chk("mid_rst_pkt",   32'(pkt_cnt_o), 32'd0);
        chk("mid_rst_rd",    32'(fifo_rd_o), 32'd0);
        exp_pkt  = 0;
        rst_n    = 1'b1;
        fifo_rst = 1'b0;
        tick(1'b1);
        push_burst(16, 8'hE0, 1'b0);
        drain(1'b0);

        // Throughput: 32 words, ready high, one beat every 2 clk
        hs_cyc_q.delete();
        track = 1'b1;
        push_burst(32, 8'h40, 1'b0);
        drain(1'b0);
        track = 1'b0;
        chk("tput_beats", 32'(hs_cyc_q.size()), 32'd32);
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            chk("tput_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd2);
        end

        // Random bursts with random ready
        repeat (6) begin
            push_burst($urandom_range(1, 40), 8'h00, 1'b1);
            drain(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
